// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: direction and
// one-hot state encodings, coordinate width and the start cell.
package snake_pkg;

  localparam int unsigned CoordW = 5;

  localparam logic [CoordW-1:0] StartX = 5'd16;
  localparam logic [CoordW-1:0] StartY = 5'd12;

  typedef enum logic [1:0] {
    DirU = 2'd0,
    DirD = 2'd1,
    DirL = 2'd2,
    DirR = 2'd3
  } dir_e;

  typedef enum logic [3:0] {
    StIni  = 4'b0001,
    StRun  = 4'b0010,
    StChk  = 4'b0100,
    StLose = 4'b1000
  } state_e;

  // U/D and L/R differ only in bit 0.
  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement tick counter: counts enabled cycles and pulses tick_o on the last
// cycle of each TICK_CYCLES period, wrapping to zero on that same edge.
module snake_tick_gen #(
  parameter int unsigned TICK_CYCLES = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntW'(TICK_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: moves the head once per tick, asks body memory
// whether the candidate cell is free, and handles food, score and game over.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W      = 32,
  parameter int unsigned GRID_H      = 24,
  parameter int unsigned TICK_CYCLES = 50
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              BtnU,
  input  logic              BtnD,
  input  logic              BtnL,
  input  logic              BtnR,
  input  logic [CoordW-1:0] FoodX,
  input  logic [CoordW-1:0] FoodY,
  input  logic              ChkAck,
  input  logic              BodyHit,
  output logic              ChkReq,
  output logic [CoordW-1:0] ChkX,
  output logic [CoordW-1:0] ChkY,
  output logic              Step,
  output logic              Grow,
  output logic              FoodReq,
  output logic [CoordW-1:0] HeadX,
  output logic [CoordW-1:0] HeadY,
  output logic [1:0]        Dir,
  output logic [7:0]        Score,
  output logic              q_Ini,
  output logic              q_Run,
  output logic              q_Chk,
  output logic              q_Lose
);

  localparam logic [CoordW:0] One = (CoordW + 1)'(1);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d, pend_q, pend_d;
  logic [CoordW-1:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [CoordW-1:0] chk_x_q, chk_x_d, chk_y_q, chk_y_d;
  logic [7:0]        score_q, score_d;
  logic              chk_req_q, chk_req_d, step_q, step_d;
  logic              grow_q, grow_d, food_req_q, food_req_d;
  logic              tick, tick_en, tick_clr;
  logic [CoordW:0]   nxt_x, nxt_y;
  logic              in_grid;

  snake_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk_i (Clk),
    .rst_i (Reset),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // One extra bit so both 0-1 underflow and max+1 overflow land out of grid.
  always_comb begin
    nxt_x = {1'b0, head_x_q};
    nxt_y = {1'b0, head_y_q};
    unique case (pend_q)
      DirU: nxt_y = {1'b0, head_y_q} - One;
      DirD: nxt_y = {1'b0, head_y_q} + One;
      DirL: nxt_x = {1'b0, head_x_q} - One;
      DirR: nxt_x = {1'b0, head_x_q} + One;
    endcase
    in_grid = (32'(nxt_x) < GRID_W) && (32'(nxt_y) < GRID_H);
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    chk_x_d    = chk_x_q;
    chk_y_d    = chk_y_q;
    score_d    = score_q;
    chk_req_d  = chk_req_q;
    step_d     = 1'b0;
    grow_d     = 1'b0;
    food_req_d = 1'b0;
    tick_en    = 1'b0;
    tick_clr   = 1'b0;

    unique case (state_q)
      StIni, StLose: begin
        if (state_q == StIni || Start) begin
          head_x_d = StartX;
          head_y_d = StartY;
          dir_d    = DirR;
          pend_d   = DirR;
          score_d  = '0;
          tick_clr = 1'b1;
        end
        if (Start) begin
          state_d = (state_q == StIni) ? StRun : StIni;
        end
      end
      StRun: begin
        tick_en = 1'b1;
        if (tick) begin
          dir_d = pend_q;
          if (in_grid) begin
            chk_x_d   = nxt_x[CoordW-1:0];
            chk_y_d   = nxt_y[CoordW-1:0];
            chk_req_d = 1'b1;
            state_d   = StChk;
          end else begin
            state_d = StLose;
          end
        end
      end
      StChk: begin
        if (ChkAck) begin
          chk_req_d = 1'b0;
          if (BodyHit) begin
            state_d = StLose;
          end else begin
            step_d   = 1'b1;
            head_x_d = chk_x_q;
            head_y_d = chk_y_q;
            state_d  = StRun;
            if (chk_x_q == FoodX && chk_y_q == FoodY) begin
              grow_d     = 1'b1;
              food_req_d = 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StIni;
    endcase

    // Reversal is judged against the direction applied after this edge.
    if (state_q == StRun || state_q == StChk) begin
      if (BtnU && dir_d != dir_opposite(DirU)) begin
        pend_d = DirU;
      end else if (BtnD && dir_d != dir_opposite(DirD)) begin
        pend_d = DirD;
      end else if (BtnL && dir_d != dir_opposite(DirL)) begin
        pend_d = DirL;
      end else if (BtnR && dir_d != dir_opposite(DirR)) begin
        pend_d = DirR;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIni;
      dir_q      <= DirR;
      pend_q     <= DirR;
      head_x_q   <= StartX;
      head_y_q   <= StartY;
      chk_x_q    <= '0;
      chk_y_q    <= '0;
      score_q    <= '0;
      chk_req_q  <= 1'b0;
      step_q     <= 1'b0;
      grow_q     <= 1'b0;
      food_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      chk_x_q    <= chk_x_d;
      chk_y_q    <= chk_y_d;
      score_q    <= score_d;
      chk_req_q  <= chk_req_d;
      step_q     <= step_d;
      grow_q     <= grow_d;
      food_req_q <= food_req_d;
    end
  end

  assign ChkReq  = chk_req_q;
  assign ChkX    = chk_x_q;
  assign ChkY    = chk_y_q;
  assign Step    = step_q;
  assign Grow    = grow_q;
  assign FoodReq = food_req_q;
  assign HeadX   = head_x_q;
  assign HeadY   = head_y_q;
  assign Dir     = dir_q;
  assign Score   = score_q;
  assign q_Ini   = (state_q == StIni);
  assign q_Run   = (state_q == StRun);
  assign q_Chk   = (state_q == StChk);
  assign q_Lose  = (state_q == StLose);

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 32, meaning playfield width in cells (x = 0..GRID_W-1).
REQ-002 SHALL have parameter GRID_H, default 24, meaning playfield height in cells (y = 0..GRID_H-1).
REQ-003 SHALL have parameter TICK_CYCLES, default 50, meaning clock cycles between movement steps (50 for simulation; board build overrides).
REQ-004 SHALL have ports, in this order:
 Clk  in  1  system clock, single clock domain
 Reset  in  1  asynchronous, active-high reset
 Start  in  1  leave INI or LOSE
 BtnU/BtnD/BtnL/BtnR  in  1 each  debounced single-cycle direction pulses
 FoodX/FoodY  in  5 each  current food cell
 ChkAck  in  1  body memory answered a lookup
 BodyHit  in  1  ChkX/ChkY occupied by the body; valid only with ChkAck
 ChkReq  out  1  lookup request to body memory
 ChkX/ChkY  out  5 each  candidate next head cell
 Step  out  1  one-cycle pulse: push new head into body memory
 Grow  out  1  with Step: keep tail (length +1)
 FoodReq  out  1  one-cycle pulse: spawn new food
 HeadX/HeadY  out  5 each  current head cell
 Dir  out  2  applied direction: 0=U, 1=D, 2=L, 3=R
 Score  out  8  food eaten
 q_Ini/q_Run/q_Chk/q_Lose  out  1 each  one-hot state, drives Ld0/Ld1/(unused)/Ld2 at top

Function
REQ-005 SHALL implement one-hot FSM with states INI, RUN, CHK, LOSE; exactly one q_* high at all times.
REQ-006 INI: HeadX=16, HeadY=12, Dir=R, pending dir=R, Score=0, tick counter=0; Start=1 -> RUN next edge, else stay.
REQ-007 RUN: tick counter increments each cycle; at count TICK_CYCLES-1 it clears and next head is computed from pending dir (U: y-1, D: y+1, L: x-1, R: x+1), Dir updated to pending dir.
REQ-008 At tick, next head outside 0..GRID_W-1 / 0..GRID_H-1 (including 0-1 underflow) -> LOSE, no ChkReq, no Step.
REQ-009 At tick, in-grid next head -> latch into ChkX/ChkY, assert ChkReq, enter CHK.
REQ-010 CHK: ChkReq and ChkX/ChkY held stable until cycle ChkAck=1; ChkAck outside CHK ignored; tick counter frozen.
REQ-011 CHK with ChkAck=1, BodyHit=1 -> LOSE next edge, no Step.
REQ-012 CHK with ChkAck=1, BodyHit=0 -> Step pulse one cycle, HeadX/HeadY <= ChkX/ChkY, -> RUN.
REQ-013 If accepted cell equals FoodX/FoodY, Grow=1 and FoodReq=1 in same cycle as Step, Score +1 saturating at 255; else Grow=0, FoodReq=0.
REQ-014 Direction pulses sampled in RUN and CHK; latest pulse wins across cycles; same-cycle priority U>D>L>R.
REQ-015 Pulse reversing applied Dir (U<->D, L<->R) SHALL be ignored.
REQ-016 Pulses in INI and LOSE ignored.
REQ-017 LOSE: HeadX/HeadY, Score frozen; Start=1 -> INI next edge.
REQ-018 Step, Grow, FoodReq, ChkReq SHALL be registered outputs, low in all states except as stated.

Reset
REQ-019 Reset=1 asynchronously forces INI and all REQ-006 values; Step, Grow, FoodReq, ChkReq=0; q_Ini=1.
REQ-020 Reset during CHK SHALL drop ChkReq immediately; any later ChkAck ignored.

Structure
REQ-021 Shared package snake_pkg SHALL hold direction encodings, state encodings, start coordinates (16,12), coordinate width 5.
REQ-022 Tick counter SHALL be sub-module snake_tick_gen (enable, clear, terminal-count pulse); rest flat.

Verification
REQ-023 Reset, Start=1 one cycle, no buttons, ChkAck=1 BodyHit=0 same cycle as ChkReq -> 15 Steps, HeadX 17..31, LOSE at 16th tick, Score=0.
REQ-024 Same with BtnD pulse one cycle after Start -> Dir=1, HeadY 13..23, LOSE at 12th tick, HeadX=16.
REQ-025 Dir=R, BtnL pulse -> ignored, Dir stays 3; BtnU and BtnL same cycle -> Dir=0 at next tick.
REQ-026 FoodX=18, FoodY=12 -> at 2nd Step Grow=1, FoodReq=1, Score=1; other Steps Grow=0.
REQ-027 ChkAck delayed 5 cycles, then BodyHit=1 -> ChkReq held 5 cycles, ChkX/ChkY stable, LOSE, no Step, HeadX=16.
REQ-028 Reset asserted mid-CHK -> ChkReq=0 and q_Ini=1 without clock edge; HeadX=16, HeadY=12.
